// File: rtl/filter_grid.sv
// rtl/filter_grid.sv - streaming 3x3 edge filter with two line buffers and saturated signed output
module filter_grid #(
  parameter int LINE_WIDTH = 1280,
  parameter int PIX_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIX_W+21:0]       data_in,
  input  logic                    vertical,
  input  logic [10:0]             x_dc,
  input  logic [10:0]             y_dc,
  input  logic signed [2:0]       v_constant,
  input  logic signed [2:0]       h_constant,
  output logic [PIX_W+1:0]        data_in_d,
  output logic signed [PIX_W-1:0] data_out
);

  localparam int CW    = 11;
  localparam int AW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int ACC_W = PIX_W + 6;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (PIX_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 << (PIX_W - 1));

  logic [CW-1:0]    in_y, in_x;
  logic [PIX_W-1:0] in_pix;
  assign {in_y, in_x, in_pix} = data_in;

  logic [CW-1:0] last_y, last_x;
  logic          seen;
  logic          accept;
  logic          accept_d;

  // A pixel is taken once per distinct coordinate; the very first one after reset always counts.
  assign accept = !seen || ({in_y, in_x} != {last_y, last_x});

  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] lb1 [LINE_WIDTH];
  logic [PIX_W-1:0] lb2 [LINE_WIDTH];
  logic [PIX_W-1:0] a1, a2;

  assign addr = in_x[AW-1:0];
  assign a1   = lb1[addr];
  assign a2   = lb2[addr];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[addr] <= a1;
      lb1[addr] <= in_pix;
    end
  end

  logic [PIX_W-1:0] w [3][3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
      last_y   <= '0;
      last_x   <= '0;
      seen     <= 1'b0;
      accept_d <= 1'b0;
    end else begin
      accept_d <= accept;
      if (accept) begin
        seen   <= 1'b1;
        last_y <= in_y;
        last_x <= in_x;
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= a2;
        w[1][2] <= a1;
        w[2][2] <= in_pix;
      end
    end
  end

  logic signed [ACC_W-1:0] t [3][3];
  logic signed [ACC_W-1:0] v_ext, h_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sat;
  logic [CW-1:0]           cx, cy;
  logic                    border;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        t[r][c] = $signed({{(ACC_W - PIX_W){1'b0}}, w[r][c]});
  end

  assign v_ext = {{(ACC_W - 3){v_constant[2]}}, v_constant};
  assign h_ext = {{(ACC_W - 3){h_constant[2]}}, h_constant};

  always_comb begin
    sum = '0;
    if (vertical)
      sum = (t[0][2] - t[0][0]) + v_ext * (t[1][2] - t[1][0]) + (t[2][2] - t[2][0]);
    else
      sum = (t[2][0] - t[0][0]) + (t[2][2] - t[0][2]) + h_ext * (t[0][1] - t[2][1]);
  end

  always_comb begin
    sat = sum;
    if (sum > SAT_MAX)
      sat = SAT_MAX;
    else if (sum < SAT_MIN)
      sat = SAT_MIN;
  end

  // Centre tap lags the newest column and row by one, wrapping in the 11-bit coordinate space.
  assign cx     = last_x - 11'd1;
  assign cy     = last_y - 11'd1;
  assign border = (cx == x_dc) || (cy == y_dc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      data_in_d <= '0;
    end else begin
      data_in_d[PIX_W+1] <= accept_d;
      if (accept_d) begin
        data_out             <= border ? '0 : sat[PIX_W-1:0];
        data_in_d[PIX_W]     <= border;
        data_in_d[PIX_W-1:0] <= w[1][1];
      end
    end
  end

endmodule

// File: tb/tb_filter_grid.sv
// tb/tb_filter_grid.sv - directed self-checking bench for filter_grid
module tb_filter_grid;

  logic               clk;
  logic               rst_n;
  logic [33:0]        data_in;
  logic               vertical;
  logic [10:0]        x_dc;
  logic [10:0]        y_dc;
  logic signed [2:0]  v_constant;
  logic signed [2:0]  h_constant;
  logic [13:0]        data_in_d;
  logic signed [11:0] data_out;

  int total;
  int bad;
  int pulses;

  filter_grid #(.LINE_WIDTH(8), .PIX_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .vertical   (vertical),
    .x_dc       (x_dc),
    .y_dc       (y_dc),
    .v_constant (v_constant),
    .h_constant (h_constant),
    .data_in_d  (data_in_d),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one new coordinate, then hold it a cycle so the result for this pixel is visible.
  task automatic feed(input int y, input int x, input int p);
    data_in = {11'(y), 11'(x), 12'(p)};
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulses = 0;
    rst_n = 1'b0;
    data_in = '0;
    vertical = 1'b1;
    v_constant = 3'sd2;
    h_constant = -3'sd2;
    x_dc = 11'd0;
    y_dc = 11'd959;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = {2'($urandom_range(3)), 32'($urandom)};
    end
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_data_in_d", data_in_d, 0);

    data_in = {11'd5, 11'd3, 12'd77};
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (data_in_d[13]) pulses++;
    end
    chk("single_accept_pulses", pulses, 1);
    chk("first_centre_pixel", data_in_d[11:0], 0);

    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 8; x++) begin
        feed(y, x, 100);
        if (y == 2 && x >= 2) chk("flat_field", data_out, 0);
        if (y == 2 && x == 4) chk("flat_centre_d", data_in_d, {1'b1, 1'b0, 12'd100});
      end

    for (int y = 3; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        feed(y, x, 100 * x);
        if (y == 5 && x >= 2) chk("col_ramp_vert", data_out, 800);
      end

    vertical = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold_until_accept", data_out, 800);

    for (int x = 0; x < 8; x++) begin
      feed(6, x, 100 * x);
      if (x >= 2) chk("col_ramp_horiz", data_out, 0);
    end

    for (int y = 10; y < 13; y++)
      for (int x = 0; x < 8; x++) begin
        feed(y, x, 100 * y);
        if (y == 12 && x >= 2) chk("row_ramp_horiz", data_out, 800);
      end

    vertical = 1'b1;
    for (int x = 0; x < 8; x++) begin
      feed(13, x, 1300);
      if (x >= 2) chk("row_ramp_vert", data_out, 0);
    end

    for (int y = 20; y < 23; y++)
      for (int x = 0; x < 3; x++)
        feed(y, x, (x == 2) ? 4095 : 0);
    chk("sat_positive", data_out, 2047);

    for (int y = 23; y < 26; y++)
      for (int x = 0; x < 3; x++)
        feed(y, x, (x == 0) ? 4095 : 0);
    chk("sat_negative", data_out, -2048);

    for (int y = 957; y < 959; y++)
      for (int x = 0; x < 4; x++)
        feed(y, x, 100 * x);
    feed(959, 0, 0);
    feed(959, 1, 100);
    chk("border_x_out", data_out, 0);
    chk("border_x_flag", data_in_d[12], 1);
    feed(959, 2, 200);
    chk("border_clear_out", data_out, 800);
    chk("border_clear_d", data_in_d, {1'b1, 1'b0, 12'd100});
    feed(960, 0, 0);
    feed(960, 1, 100);
    feed(960, 2, 200);
    chk("border_y_out", data_out, 0);
    chk("border_y_flag", data_in_d[12], 1);
    chk("border_y_centre", data_in_d[11:0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
